sap1_control_sequencer: RTL and testbench
=========================================

// Module: sap1_control_sequencer
// PURPOSE
//   SAP-1 controller-sequencer: 6-state ring counter (T1..T6) plus opcode decoder.
//   Drives the control word that sequences pc, mar, ram, instruction register, accumulator, ALU, B and output registers over the shared bus.
//   Implements the fetch cycle (T1-T3) and execute cycle (T4-T6) for LDA/ADD/SUB/OUT/HLT.
//   Owns the halt state.
// PARAMETERS
//   RING_W    6   number of T-states; ring counter width (fixed at 6 for SAP-1)
//   OPCODE_W  4   opcode width (upper nibble of instruction register)
//   ICNT_W    8   width of retired-instruction counter
// PORTS
//   CLK        in   1         system clock; all state updates on rising edge
//   CLR        in   1         asynchronous, active-low reset
//   opcode     in   OPCODE_W  instruction register upper nibble; sampled combinationally in T4-T6
//   Cp         out  1         increment program counter
//   Ep         out  1         program counter drives bus
//   Lm         out  1         load MAR from bus
//   CE         out  1         RAM drives bus (active-high in this design)
//   Li         out  1         load instruction register
//   Ei         out  1         instruction register low nibble drives bus
//   La         out  1         load accumulator
//   Ea         out  1         accumulator drives bus
//   Su         out  1         ALU subtract (0 = add)
//   Eu         out  1         ALU drives bus
//   Lb         out  1         load B register
//   Lo         out  1         load output register
//   hlt        out  1         halted; gates nothing internally, exported for clock gating/status
//   t_state    out  RING_W    one-hot ring value, bit0 = T1
//   instr_done out  1         1-cycle pulse in the final T-state of each instruction
//   instr_cnt  out  ICNT_W    count of retired instructions, wraps
// BEHAVIOUR
//   Reset (CLR=0, async)
//     - t_state=6'b000001, hlt=0, instr_cnt=0.
//     - All control outputs and instr_done forced 0 while CLR=0.
//   Ring counter
//     - Advances one-hot T1->T2->..->T6->T1 on each CLK rising edge when hlt=0.
//     - Any non-one-hot value (illegal) reloads T1 next edge.
//   Control word
//     - Combinational from registered t_state (and opcode in T4-T6); all signals active-high.
//     - Loads in datapath occur at the rising edge ending the T-state.
//   Fetch cycle (all opcodes)
//     - T1: Ep,Lm
//     - T2: Cp
//     - T3: CE,Li
//   Execute cycle
//     - LDA 0000: T4 Ei,Lm | T5 CE,La    | T6 none
//     - ADD 0001: T4 Ei,Lm | T5 CE,Lb    | T6 Eu,La
//     - SUB 0010: T4 Ei,Lm | T5 CE,Lb    | T6 Su,Eu,La
//     - OUT 1110: T4 Ea,Lo | T5 none     | T6 none
//     - HLT 1111: T4 none; hlt set at T4 rising edge exit (registered), ring frozen at T5.
//   Halted state
//     - All controls 0, instr_done=0.
//     - Held until CLR low; opcode changes ignored.
//     - HLT counts as retired: instr_done pulses in T4.
//   Undefined opcodes: NOP; fetch only, no bus drivers in T4-T6.
//   Bus exclusivity
//     - At most one of Ep,CE,Ei,Ea,Eu asserted in any cycle (invariant).
//   instr_done / instr_cnt
//     - instr_done=1 in last executed T-state (T6 by default; T4 for HLT).
//     - instr_cnt increments on that edge, modulo 2^ICNT_W.
//   Mid-instruction reset
//     - CLR low at any T-state aborts immediately; restart from T1, no partial count.
// CONFIGURATION
//   SAP1_EARLY_FETCH_EN defined: variable-length instructions.
//     - Ring returns to T1 after last non-empty T-state: LDA after T5, OUT after T4, undefined after T3.
//     - ADD/SUB still use T6.
//     - instr_done marks that final state.
//   SAP1_EARLY_FETCH_EN undefined: every non-HLT instruction takes exactly 6 cycles.
// TESTING
//   1. CLR=0 mid-T3 -> outputs 0 immediately; release -> t_state=000001, Ep=Lm=1, instr_cnt=0.
//   2. opcode=0000 -> T1..T6 control words exactly as table; instr_done in T6 only; instr_cnt 0->1.
//   3. opcode=0010 -> T6 shows Su=Eu=La=1; next cycle t_state=000001.
//   4. opcode=1111 -> hlt=1 after T4 edge.
//      Then 20 cycles: t_state stays 010000, all controls 0, instr_cnt unchanged.
//   5. opcode=0101 (undefined) -> T4-T6 all controls 0.
//      EARLY_FETCH build: T1 follows T3.
//   6. 256 ADDs -> instr_cnt wraps 255->0.
//      Every cycle assert at most one bus driver active.

Source files
------------

// File: rtl/sap1_control_sequencer.sv
// SAP-1 controller-sequencer: one-hot T1..T6 ring counter, opcode decode and halt/retire tracking.
// Optional build macro SAP1_EARLY_FETCH_EN: variable-length instructions (ring restarts after last busy T-state).
module sap1_control_sequencer #(
   parameter int RING_W   = 6,
   parameter int OPCODE_W = 4,
   parameter int ICNT_W   = 8
) (
   input  logic                CLK,
   input  logic                CLR,
   input  logic [OPCODE_W-1:0] opcode,
   output logic                Cp,
   output logic                Ep,
   output logic                Lm,
   output logic                CE,
   output logic                Li,
   output logic                Ei,
   output logic                La,
   output logic                Ea,
   output logic                Su,
   output logic                Eu,
   output logic                Lb,
   output logic                Lo,
   output logic                hlt,
   output logic [RING_W-1:0]   t_state,
   output logic                instr_done,
   output logic [ICNT_W-1:0]   instr_cnt
);

   localparam logic [RING_W-1:0] T1 = RING_W'(1);
   localparam logic [RING_W-1:0] T2 = RING_W'(2);
   localparam logic [RING_W-1:0] T3 = RING_W'(4);
   localparam logic [RING_W-1:0] T4 = RING_W'(8);
   localparam logic [RING_W-1:0] T5 = RING_W'(16);
   localparam logic [RING_W-1:0] T6 = RING_W'(32);

   localparam logic [OPCODE_W-1:0] OP_LDA = OPCODE_W'(4'h0);
   localparam logic [OPCODE_W-1:0] OP_ADD = OPCODE_W'(4'h1);
   localparam logic [OPCODE_W-1:0] OP_SUB = OPCODE_W'(4'h2);
   localparam logic [OPCODE_W-1:0] OP_OUT = OPCODE_W'(4'hE);
   localparam logic [OPCODE_W-1:0] OP_HLT = OPCODE_W'(4'hF);

   typedef struct packed {
      logic cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo;
   } ctrl_t;

   ctrl_t               ctrl;
   logic [RING_W-1:0]   t_next;
   logic                hlt_next;
   logic [ICNT_W-1:0]   cnt_next;
   logic                onehot;
   logic                last;
   logic                done;
   logic                is_hlt;

   assign onehot = $onehot(t_state);
   assign is_hlt = (opcode == OP_HLT);
   assign done   = onehot && last && !hlt;

   // Final T-state of the current instruction.
   always_comb begin
      last = t_state[5];
`ifdef SAP1_EARLY_FETCH_EN
      // Undefined opcodes end in T3, so the decision uses the opcode seen during T3.
      case (opcode)
         OP_LDA:         last = t_state[4];
         OP_ADD, OP_SUB: last = t_state[5];
         OP_OUT, OP_HLT: last = t_state[3];
         default:        last = t_state[2];
      endcase
`else
      if (is_hlt) last = t_state[3];
`endif
   end

   always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR) begin
         t_state   <= T1;
         hlt       <= 1'b0;
         instr_cnt <= '0;
      end else begin
         t_state   <= t_next;
         hlt       <= hlt_next;
         instr_cnt <= cnt_next;
      end
   end

   always_comb begin
      t_next   = t_state;
      hlt_next = hlt;
      cnt_next = instr_cnt;
      if (!hlt) begin
         if (!onehot)
            t_next = T1;
         else if (done && !is_hlt)
            t_next = T1;
         else
            t_next = {t_state[RING_W-2:0], t_state[RING_W-1]};
         // HLT retires at T4 and the ring parks at T5.
         if (done) begin
            cnt_next = instr_cnt + 1'b1;
            if (is_hlt) hlt_next = 1'b1;
         end
      end
   end

   always_comb begin
      ctrl = '0;
      if (CLR && !hlt) begin
         case (t_state)
            T1: begin ctrl.ep = 1'b1; ctrl.lm = 1'b1; end
            T2: ctrl.cp = 1'b1;
            T3: begin ctrl.ce = 1'b1; ctrl.li = 1'b1; end
            T4: begin
               case (opcode)
                  OP_LDA, OP_ADD, OP_SUB: begin ctrl.ei = 1'b1; ctrl.lm = 1'b1; end
                  OP_OUT:                 begin ctrl.ea = 1'b1; ctrl.lo = 1'b1; end
                  default: ;
               endcase
            end
            T5: begin
               case (opcode)
                  OP_LDA:         begin ctrl.ce = 1'b1; ctrl.la = 1'b1; end
                  OP_ADD, OP_SUB: begin ctrl.ce = 1'b1; ctrl.lb = 1'b1; end
                  default: ;
               endcase
            end
            T6: begin
               case (opcode)
                  OP_ADD: begin ctrl.eu = 1'b1; ctrl.la = 1'b1; end
                  OP_SUB: begin ctrl.su = 1'b1; ctrl.eu = 1'b1; ctrl.la = 1'b1; end
                  default: ;
               endcase
            end
            default: ;
         endcase
      end
   end

   assign {Cp, Ep, Lm, CE, Li, Ei, La, Ea, Su, Eu, Lb, Lo} = ctrl;
   assign instr_done = CLR && done;

endmodule

// File: tb/tb_sap1_control_sequencer.sv
// Directed bench for sap1_control_sequencer: reset, fetch/execute words, halt, NOP, counter wrap.
module tb_sap1_control_sequencer;

   logic        CLK;
   logic        CLR;
   logic [3:0]  opcode;
   logic        Cp, Ep, Lm, CE, Li, Ei, La, Ea, Su, Eu, Lb, Lo;
   logic        hlt;
   logic [5:0]  t_state;
   logic        instr_done;
   logic [7:0]  instr_cnt;
   logic [11:0] ctrl;

   int checks = 0;
   int errors = 0;
   logic [7:0] exp_cnt;

   sap1_control_sequencer #(.RING_W(6), .OPCODE_W(4), .ICNT_W(8)) dut (
      .CLK(CLK), .CLR(CLR), .opcode(opcode),
      .Cp(Cp), .Ep(Ep), .Lm(Lm), .CE(CE), .Li(Li), .Ei(Ei), .La(La), .Ea(Ea),
      .Su(Su), .Eu(Eu), .Lb(Lb), .Lo(Lo),
      .hlt(hlt), .t_state(t_state), .instr_done(instr_done), .instr_cnt(instr_cnt)
   );

   assign ctrl = {Cp, Ep, Lm, CE, Li, Ei, La, Ea, Su, Eu, Lb, Lo};

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Bus drivers must never collide.
   always @(negedge CLK) begin
      checks++;
      if ($countones({Ep, CE, Ei, Ea, Eu}) > 1) begin
         errors++;
         $display("FAIL bus_excl t=%0t drivers Ep%b CE%b Ei%b Ea%b Eu%b expected at most one",
                  $time, Ep, CE, Ei, Ea, Eu);
      end
   end

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   // Leaves the DUT in T1, a few ns after a rising edge.
   task automatic resync();
      step();
      CLR = 1'b0;
      #1;
      CLR = 1'b1;
      exp_cnt = 8'd0;
   endtask

   task automatic test_reset();
      CLR = 1'b0;
      opcode = 4'h0;
      step(); step();
      checks++;
      if ({t_state, ctrl, instr_done, hlt, instr_cnt} !== {6'b000001, 12'h000, 1'b0, 1'b0, 8'd0}) begin
         errors++;
         $display("FAIL reset_hold got t=%b ctrl=%h done=%b hlt=%b cnt=%0d expected t=000001 ctrl=000 done=0 hlt=0 cnt=0",
                  t_state, ctrl, instr_done, hlt, instr_cnt);
      end
      #2 CLR = 1'b1;
      step(); step();
      checks++;
      if ({t_state, ctrl} !== {6'b000100, 12'h180}) begin
         errors++;
         $display("FAIL reset_preT3 got t=%b ctrl=%h expected t=000100 ctrl=180", t_state, ctrl);
      end
      #3 CLR = 1'b0;
      #1;
      checks++;
      if ({t_state, ctrl, instr_done} !== {6'b000001, 12'h000, 1'b0}) begin
         errors++;
         $display("FAIL reset_midT3 got t=%b ctrl=%h done=%b expected t=000001 ctrl=000 done=0",
                  t_state, ctrl, instr_done);
      end
      #2 CLR = 1'b1;
      #1;
      checks++;
      if ({t_state, ctrl, instr_cnt} !== {6'b000001, 12'h600, 8'd0}) begin
         errors++;
         $display("FAIL reset_release got t=%b ctrl=%h cnt=%0d expected t=000001 ctrl=600 cnt=0",
                  t_state, ctrl, instr_cnt);
      end
   endtask

   // LDA, ADD, SUB, OUT, then undefined 0101, back to back.
   task automatic test_execute();
      logic [3:0]  ops [5];
      logic [11:0] words [5][6];
      int          len [5];
      logic [5:0]  exp_t;
      ops = '{4'h0, 4'h1, 4'h2, 4'hE, 4'h5};
      words[0] = '{12'h600, 12'h800, 12'h180, 12'h240, 12'h120, 12'h000};
      words[1] = '{12'h600, 12'h800, 12'h180, 12'h240, 12'h102, 12'h024};
      words[2] = '{12'h600, 12'h800, 12'h180, 12'h240, 12'h102, 12'h02C};
      words[3] = '{12'h600, 12'h800, 12'h180, 12'h011, 12'h000, 12'h000};
      words[4] = '{12'h600, 12'h800, 12'h180, 12'h000, 12'h000, 12'h000};
`ifdef SAP1_EARLY_FETCH_EN
      len = '{5, 6, 6, 4, 3};
`else
      len = '{6, 6, 6, 6, 6};
`endif
      resync();
      for (int o = 0; o < 5; o++) begin
         opcode = ops[o];
         #1;
         for (int k = 0; k < len[o]; k++) begin
            exp_t = 6'b000001 << k;
            checks++;
            if ({t_state, ctrl, instr_done, hlt} !== {exp_t, words[o][k], (k == len[o] - 1), 1'b0}) begin
               errors++;
               $display("FAIL exec op=%h T%0d got t=%b ctrl=%h done=%b hlt=%b expected t=%b ctrl=%h done=%b hlt=0",
                        ops[o], k + 1, t_state, ctrl, instr_done, hlt, exp_t, words[o][k], (k == len[o] - 1));
            end
            step();
         end
         exp_cnt = exp_cnt + 8'd1;
         checks++;
         if ({t_state, instr_cnt} !== {6'b000001, exp_cnt}) begin
            errors++;
            $display("FAIL exec_retire op=%h got t=%b cnt=%0d expected t=000001 cnt=%0d",
                     ops[o], t_state, instr_cnt, exp_cnt);
         end
      end
   endtask

   task automatic test_halt();
      resync();
      opcode = 4'hF;
      #1;
      step(); step(); step();
      checks++;
      if ({t_state, ctrl, instr_done, hlt} !== {6'b001000, 12'h000, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL hlt_T4 got t=%b ctrl=%h done=%b hlt=%b expected t=001000 ctrl=000 done=1 hlt=0",
                  t_state, ctrl, instr_done, hlt);
      end
      step();
      checks++;
      if ({t_state, ctrl, instr_done, hlt, instr_cnt} !== {6'b010000, 12'h000, 1'b0, 1'b1, 8'd1}) begin
         errors++;
         $display("FAIL hlt_set got t=%b ctrl=%h done=%b hlt=%b cnt=%0d expected t=010000 ctrl=000 done=0 hlt=1 cnt=1",
                  t_state, ctrl, instr_done, hlt, instr_cnt);
      end
      for (int i = 0; i < 20; i++) begin
         opcode = 4'(i);
         step();
         checks++;
         if ({t_state, ctrl, instr_done, hlt, instr_cnt} !== {6'b010000, 12'h000, 1'b0, 1'b1, 8'd1}) begin
            errors++;
            $display("FAIL hlt_hold cyc=%0d got t=%b ctrl=%h done=%b hlt=%b cnt=%0d expected t=010000 ctrl=000 done=0 hlt=1 cnt=1",
                     i, t_state, ctrl, instr_done, hlt, instr_cnt);
         end
      end
      CLR = 1'b0;
      #1;
      checks++;
      if ({hlt, t_state, instr_cnt} !== {1'b0, 6'b000001, 8'd0}) begin
         errors++;
         $display("FAIL hlt_clear got hlt=%b t=%b cnt=%0d expected hlt=0 t=000001 cnt=0", hlt, t_state, instr_cnt);
      end
      CLR = 1'b1;
   endtask

   task automatic test_wrap();
      int dones;
      resync();
      opcode = 4'h1;
      dones = 0;
      for (int n = 0; n < 256; n++) begin
         for (int k = 0; k < 6; k++) begin
            #1;
            if (instr_done) dones++;
            step();
         end
         if (n == 254) begin
            checks++;
            if (instr_cnt !== 8'd255) begin
               errors++;
               $display("FAIL wrap_255 got cnt=%0d expected 255", instr_cnt);
            end
         end
      end
      checks++;
      if ({instr_cnt, t_state} !== {8'd0, 6'b000001}) begin
         errors++;
         $display("FAIL wrap_0 got cnt=%0d t=%b expected cnt=0 t=000001", instr_cnt, t_state);
      end
      checks++;
      if (dones != 256) begin
         errors++;
         $display("FAIL wrap_pulses got %0d expected 256", dones);
      end
   endtask

   initial begin
      CLR = 1'b0;
      opcode = 4'h0;
      exp_cnt = 8'd0;
      test_reset();
      test_execute();
      test_halt();
      test_wrap();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
